gold_interaction_ctrl: RTL

//  Digger-side counterpart of the gold-bag movement FSM.
//  - Consumes gold_state, gold position, digger position and the raw digger/gold pixel-overlap pulse.
//  - Produces what the gold FSM consumes: collision push, push side and been_eaten.
//  - Produces game events: digger_killed and score_add.
//  - One instance per gold bag, between the collision matrix and the gold mover/score block.

---
 rtl/gold_interaction_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gold_interaction_ctrl.sv
// Digger-side interaction controller for one gold bag: turns frame-latched overlap
// into push / kill / eat events for the gold FSM and the score block.
module gold_interaction_ctrl #(
    parameter int PUSH_COOLDOWN_FRAMES = 16,
    parameter int ROW_TOL              = 16,
    parameter int KILL_Y_MARGIN        = 8,
    parameter int SCORE_VALUE          = 500
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        hit,
    input  logic [3:0]  gold_state,
    input  logic [10:0] goldX,
    input  logic [10:0] goldY,
    input  logic [10:0] diggerX,
    input  logic [10:0] diggerY,
    output logic        push,
    output logic        side,
    output logic        been_eaten,
    output logic        digger_killed,
    output logic        score_add,
    output logic [11:0] score_value,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        WATCH    = 3'd0,
        COOLDOWN = 3'd1,
        KILLED   = 3'd2,
        EAT_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(PUSH_COOLDOWN_FRAMES + 1);
    localparam logic signed [11:0] KILL_MARGIN = 12'(KILL_Y_MARGIN);
    localparam logic [11:0]        ROW_LIMIT   = 12'(ROW_TOL);
    localparam logic [CNT_W-1:0]   CNT_LOAD    = CNT_W'(PUSH_COOLDOWN_FRAMES - 1);

    localparam logic [3:0] GS_IDLE    = 4'd0;
    localparam logic [3:0] GS_FALLING = 4'd1;
    localparam logic [3:0] GS_CRASHED = 4'd2;
    localparam logic [3:0] GS_EATEN   = 4'd3;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             hit_flag, hit_flag_n;
    logic             push_n, side_n, eaten_n, killed_n, score_add_n;
    logic [11:0]      score_value_n;

    // Coordinates are sign-extended so a bag or digger partly off-screen compares correctly.
    logic signed [11:0] dy;
    logic [11:0]        dy_abs;
    logic               row_ok, below_ok, digger_right;

    assign dy           = $signed({diggerY[10], diggerY}) - $signed({goldY[10], goldY});
    assign dy_abs       = dy[11] ? 12'(-dy) : 12'(dy);
    assign row_ok       = dy_abs < ROW_LIMIT;
    assign below_ok     = dy >= KILL_MARGIN;
    assign digger_right = $signed(diggerX) > $signed(goldX);

    assign fsm_state = state;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        hit_flag_n    = hit_flag | hit;
        push_n        = 1'b0;
        side_n        = side;
        eaten_n       = been_eaten;
        killed_n      = 1'b0;
        score_add_n   = 1'b0;
        score_value_n = 12'd0;

        if (startOfFrame) begin
            // The overlap seen on the frame-start cycle itself belongs to no frame.
            hit_flag_n = 1'b0;
            case (state)
                WATCH: begin
                    if (hit_flag) begin
                        if (gold_state == GS_IDLE && row_ok) begin
                            push_n  = 1'b1;
                            side_n  = digger_right;
                            cnt_n   = CNT_LOAD;
                            state_n = COOLDOWN;
                        end else if (gold_state == GS_FALLING && below_ok) begin
                            killed_n = 1'b1;
                            state_n  = KILLED;
                        end else if (gold_state == GS_CRASHED) begin
                            eaten_n       = 1'b1;
                            score_add_n   = 1'b1;
                            score_value_n = 12'(SCORE_VALUE);
                            state_n       = EAT_WAIT;
                        end
                    end
                end
                COOLDOWN: begin
                    if (cnt == '0) state_n = WATCH;
                    else           cnt_n   = cnt - 1'b1;
                end
                KILLED: begin
                    if (gold_state != GS_FALLING) state_n = WATCH;
                end
                EAT_WAIT: begin
                    if (gold_state == GS_EATEN) begin
                        eaten_n = 1'b0;
                        side_n  = 1'b0;
                        state_n = DONE;
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = WATCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= WATCH;
            cnt           <= '0;
            hit_flag      <= 1'b0;
            push          <= 1'b0;
            side          <= 1'b0;
            been_eaten    <= 1'b0;
            digger_killed <= 1'b0;
            score_add     <= 1'b0;
            score_value   <= 12'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            hit_flag      <= hit_flag_n;
            push          <= push_n;
            side          <= side_n;
            been_eaten    <= eaten_n;
            digger_killed <= killed_n;
            score_add     <= score_add_n;
            score_value   <= score_value_n;
        end
    end

endmodule
